// File: rtl/alu_pkg.sv
// Shared constants and types for the external ALU responder.
// CSR bit positions, opcode encodings and the handshake state set.
package alu_pkg;

  localparam int ALUDATABITS   = 32;
  localparam int ALUOPBITS     = 4;
  localparam int ALUCSRINBITS  = 3;
  localparam int ALUCSROUTBITS = 3;

  localparam int IN_PROT    = 0;
  localparam int IN_OP1     = 1;
  localparam int IN_OP2     = 2;
  localparam int OUT_OP1RDY = 0;
  localparam int OUT_OP2RDY = 1;
  localparam int OUT_VALID  = 2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [2:0] {
    S_WAIT_OP1,
    S_WAIT_OP2,
    S_COMPUTE,
    S_WRITE,
    S_RES_WAIT_PROT,
    S_RES_WAIT_REL
  } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add iterative multiplier, one partial product per cycle.
// done rises W cycles after start and holds until the next start.
module alu_seq_mul #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(W);
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (busy) begin
      if (mplier[0])
        acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/ext_alu_responder.sv
// Responder side of the FU/external-ALU CSR handshake.
// Latches OP1/OP2 on strobes, computes, publishes OP3 under write-protect.
module ext_alu_responder #(
  parameter int ALUDATABITS = 32,
  parameter int ALUOPBITS   = 4,
  parameter int FIXED_LAT   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [ALUDATABITS-1:0]               OP1,
  input  logic [ALUDATABITS-1:0]               OP2,
  input  logic [ALUOPBITS-1:0]                 ALUOP,
  input  logic [alu_pkg::ALUCSRINBITS-1:0]     CSR_ALU_IN,
  output logic [alu_pkg::ALUCSROUTBITS-1:0]    CSR_ALU_OUT,
  output logic [ALUDATABITS-1:0]               OP3
);

  import alu_pkg::*;

  alu_state_e             state;
  logic [ALUDATABITS-1:0] op1_q;
  logic [ALUDATABITS-1:0] op2_q;
  logic [ALUOPBITS-1:0]   op_q;
  logic [7:0]             cnt;

  logic                   mul_start;
  logic                   mul_done;
  logic [ALUDATABITS-1:0] mul_p;
  logic [ALUDATABITS-1:0] alu_res;
  logic [ALUDATABITS-1:0] res;
  logic [4:0]             shamt;
  logic                   is_mul;
  logic                   done_now;
  logic                   prot;

  assign prot   = CSR_ALU_IN[IN_PROT];
  assign is_mul = (op_q == OP_MUL);
  assign shamt  = op2_q[4:0];

  // Multiplier takes OP2 straight from the port on the accept edge.
  assign mul_start = (state == S_WAIT_OP2) &&
                     CSR_ALU_IN[IN_OP2] && is_mul;

  alu_seq_mul #(.W(ALUDATABITS)) u_mul (
    .clk     (clk),
    .rst_n   (reset_n),
    .start   (mul_start),
    .a       (op1_q),
    .b       (OP2),
    .done    (mul_done),
    .product (mul_p)
  );

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = op1_q + op2_q;
      OP_SUB:  alu_res = op1_q - op2_q;
      OP_AND:  alu_res = op1_q & op2_q;
      OP_OR:   alu_res = op1_q | op2_q;
      OP_XOR:  alu_res = op1_q ^ op2_q;
      OP_SLL:  alu_res = op1_q << shamt;
      OP_SRL:  alu_res = op1_q >> shamt;
      OP_SRA:  alu_res = $signed(op1_q) >>> shamt;
      OP_SLT:  alu_res = {{(ALUDATABITS-1){1'b0}},
                          $signed(op1_q) < $signed(op2_q)};
      OP_SLTU: alu_res = {{(ALUDATABITS-1){1'b0}},
                          op1_q < op2_q};
      default: alu_res = '0;
    endcase
  end

  assign res      = is_mul ? mul_p : alu_res;
  assign done_now = is_mul ? mul_done : (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_WAIT_OP1;
      CSR_ALU_OUT <= 3'b001;
      OP3         <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      op_q        <= '0;
      cnt         <= '0;
    end else begin
      unique case (state)
        S_WAIT_OP1: if (CSR_ALU_IN[IN_OP1]) begin
          op1_q                   <= OP1;
          op_q                    <= ALUOP;
          CSR_ALU_OUT[OUT_OP1RDY] <= 1'b0;
          CSR_ALU_OUT[OUT_OP2RDY] <= 1'b1;
          state                   <= S_WAIT_OP2;
        end
        S_WAIT_OP2: if (CSR_ALU_IN[IN_OP2]) begin
          op2_q                   <= OP2;
          cnt                     <= 8'(FIXED_LAT - 1);
          CSR_ALU_OUT[OUT_OP2RDY] <= 1'b0;
          state                   <= S_COMPUTE;
        end
        // Finishing compute writes directly when unprotected.
        S_COMPUTE: if (done_now) begin
          if (!prot) begin
            OP3                    <= res;
            CSR_ALU_OUT[OUT_VALID] <= 1'b1;
            state                  <= S_RES_WAIT_PROT;
          end else begin
            state <= S_WRITE;
          end
        end else if (cnt != '0) begin
          cnt <= cnt - 8'd1;
        end
        S_WRITE: if (!prot) begin
          OP3                    <= res;
          CSR_ALU_OUT[OUT_VALID] <= 1'b1;
          state                  <= S_RES_WAIT_PROT;
        end
        S_RES_WAIT_PROT: if (prot) begin
          state <= S_RES_WAIT_REL;
        end
        S_RES_WAIT_REL: if (!prot) begin
          CSR_ALU_OUT[OUT_VALID]  <= 1'b0;
          CSR_ALU_OUT[OUT_OP1RDY] <= 1'b1;
          state                   <= S_WAIT_OP1;
        end
        default: state <= S_WAIT_OP1;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_alu_responder.sv
// Randomized self-checking bench for ext_alu_responder.
// Expected results come from a plain-arithmetic opcode model.
module tb_ext_alu_responder;

  localparam int FL = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic [3:0]  ALUOP;
  logic [2:0]  CSR_ALU_IN;
  logic [2:0]  CSR_ALU_OUT;
  logic [31:0] OP3;

  int vectors = 0;
  int errors  = 0;

  ext_alu_responder #(
    .ALUDATABITS(32),
    .ALUOPBITS  (4),
    .FIXED_LAT  (FL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .OP1        (OP1),
    .OP2        (OP2),
    .ALUOP      (ALUOP),
    .CSR_ALU_IN (CSR_ALU_IN),
    .CSR_ALU_OUT(CSR_ALU_OUT),
    .OP3        (OP3)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input int op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] wide;
    int sh;
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return 32'($signed(a) >>> sh);
      8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: begin
        wide = 64'(a) * 64'(b);
        return wide[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input int op);
    return (op == 10) ? 33 : FL;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op1(input logic [31:0] a, input int op);
    OP1 = a;
    ALUOP = 4'(op);
    CSR_ALU_IN[1] = 1'b1;
    tick();
    CSR_ALU_IN[1] = 1'b0;
  endtask

  task automatic send_op2(input logic [31:0] b);
    OP2 = b;
    CSR_ALU_IN[2] = 1'b1;
    tick();
    CSR_ALU_IN[2] = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int viol);
    lat = 0;
    viol = 0;
    do begin
      tick();
      lat++;
      if (CSR_ALU_OUT[1:0] != 2'b00) viol++;
    end while (!CSR_ALU_OUT[2] && lat < 200);
  endtask

  task automatic release_res();
    CSR_ALU_IN[0] = 1'b1;
    tick();
    CSR_ALU_IN[0] = 1'b0;
    tick();
  endtask

  task automatic run_txn(input int op, input logic [31:0] a,
                         input logic [31:0] b,
                         output int lat, output int viol);
    send_op1(a, op);
    send_op2(b);
    wait_valid(lat, viol);
  endtask

  task automatic test_reset();
    int lat, viol;
    reset_n = 1'b0;
    CSR_ALU_IN = 3'b000;
    OP1 = '0; OP2 = '0; ALUOP = '0;
    repeat (2) tick();
    vectors++;
    if (CSR_ALU_OUT !== 3'b001) begin
      errors++;
      $display("FAIL reset_out got %b want 001", CSR_ALU_OUT);
    end
    vectors++;
    if (OP3 !== 32'd0) begin
      errors++;
      $display("FAIL reset_op3 got %h want 0", OP3);
    end
    reset_n = 1'b1;
    tick();
    run_txn(0, 32'd3, 32'd4, lat, viol);
    vectors++;
    if (OP3 !== 32'd7) begin
      errors++;
      $display("FAIL pre_add got %h want 7", OP3);
    end
    release_res();
    send_op1(32'h1234, 10);
    send_op2(32'h5678);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    vectors++;
    if (CSR_ALU_OUT !== 3'b001 || OP3 !== 32'd0) begin
      errors++;
      $display("FAIL midreset got out=%b op3=%h want 001/0",
               CSR_ALU_OUT, OP3);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    run_txn(0, 32'd5, 32'd7, lat, viol);
    vectors++;
    if (OP3 !== 32'd12 || lat !== FL) begin
      errors++;
      $display("FAIL post_reset_add got %h lat %0d want 12 lat %0d",
               OP3, lat, FL);
    end
    release_res();
  endtask

  task automatic test_add_wrap();
    int lat, viol;
    run_txn(0, 32'hFFFF_FFFF, 32'd1, lat, viol);
    vectors++;
    if (OP3 !== 32'd0 || lat !== FL || CSR_ALU_OUT !== 3'b100) begin
      errors++;
      $display("FAIL add_wrap got %h lat %0d out %b want 0 lat %0d 100",
               OP3, lat, CSR_ALU_OUT, FL);
    end
    release_res();
    vectors++;
    if (CSR_ALU_OUT !== 3'b001) begin
      errors++;
      $display("FAIL add_release got %b want 001", CSR_ALU_OUT);
    end
  endtask

  task automatic test_mul();
    int lat, viol;
    run_txn(10, 32'h0001_0003, 32'h0002_0005, lat, viol);
    vectors++;
    if (OP3 !== 32'h000B_000F || lat !== 33) begin
      errors++;
      $display("FAIL mul got %h lat %0d want 000b000f lat 33", OP3, lat);
    end
    vectors++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL mul_rdy got %0d busy-ready cycles want 0", viol);
    end
    release_res();
  endtask

  task automatic test_protect();
    logic [31:0] prev, a, b;
    int bad;
    prev = OP3;
    a = $urandom;
    b = $urandom;
    bad = 0;
    send_op1(a, 4);
    CSR_ALU_IN[0] = 1'b1;
    send_op2(b);
    repeat (FL + 4) begin
      tick();
      if (OP3 !== prev || CSR_ALU_OUT[2] !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL protect_hold got %0d bad cycles want 0", bad);
    end
    CSR_ALU_IN[0] = 1'b0;
    tick();
    vectors++;
    if (OP3 !== model(4, a, b) || CSR_ALU_OUT !== 3'b100) begin
      errors++;
      $display("FAIL protect_update got %h/%b want %h/100",
               OP3, CSR_ALU_OUT, model(4, a, b));
    end
    release_res();
  endtask

  task automatic test_strobe_misuse();
    logic [31:0] a, b;
    int lat, viol;
    a = $urandom;
    b = $urandom;
    OP1 = a;
    OP2 = ~b;
    ALUOP = 4'd1;
    CSR_ALU_IN[2:1] = 2'b11;
    tick();
    CSR_ALU_IN[2:1] = 2'b00;
    tick();
    vectors++;
    if (CSR_ALU_OUT !== 3'b010) begin
      errors++;
      $display("FAIL dual_strobe got %b want 010", CSR_ALU_OUT);
    end
    send_op2(b);
    OP2 = b ^ 32'h5A5A_5A5A;
    CSR_ALU_IN[2] = 1'b1;
    wait_valid(lat, viol);
    CSR_ALU_IN[2] = 1'b0;
    vectors++;
    if (OP3 !== model(1, a, b) || lat !== FL) begin
      errors++;
      $display("FAIL compute_strobe got %h lat %0d want %h lat %0d",
               OP3, lat, model(1, a, b), FL);
    end
    release_res();
  endtask

  task automatic test_back_to_back();
    int lat, viol;
    int ops[3] = '{7, 8, 13};
    logic [31:0] as[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] bs[3] = '{32'd4, 32'd1, 32'h9ABC_DEF0};
    logic [31:0] want[3] = '{32'hF800_0000, 32'd1, 32'd0};
    for (int i = 0; i < 3; i++) begin
      run_txn(ops[i], as[i], bs[i], lat, viol);
      vectors++;
      if (OP3 !== want[i] || OP3 !== model(ops[i], as[i], bs[i])) begin
        errors++;
        $display("FAIL b2b_%0d got %h want %h", i, OP3, want[i]);
      end
      release_res();
      vectors++;
      if (CSR_ALU_OUT !== 3'b001) begin
        errors++;
        $display("FAIL b2b_rel_%0d got %b want 001", i, CSR_ALU_OUT);
      end
    end
  endtask

  task automatic test_random();
    int lat, viol, op;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = int'($urandom_range(15));
      a = $urandom;
      b = $urandom;
      run_txn(op, a, b, lat, viol);
      vectors++;
      if (OP3 !== model(op, a, b) || lat !== model_lat(op)) begin
        errors++;
        $display("FAIL rand_%0d op %0d got %h lat %0d want %h lat %0d",
                 i, op, OP3, lat, model(op, a, b), model_lat(op));
      end
      release_res();
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_mul();
    test_protect();
    test_strobe_misuse();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
